// File: rtl/traffic_pkg.sv
// ============================================================================
// Module   : traffic_pkg
// Brief    : Shared light encodings, direction states and error codes for
//            traffic_light_monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    typedef enum logic [1:0] {
        DIR_RED     = 2'd0,
        DIR_GREEN   = 2'd1,
        DIR_YELLOW  = 2'd2,
        DIR_ILLEGAL = 2'd3
    } dir_state_t;

    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_ENC         = 3'd1;
    localparam logic [2:0] ERR_CONFLICT    = 3'd2;
    localparam logic [2:0] ERR_SEQ         = 3'd3;
    localparam logic [2:0] ERR_GREEN_SHORT = 3'd4;
    localparam logic [2:0] ERR_YELLOW_LEN  = 3'd5;
    localparam logic [2:0] ERR_WDOG        = 3'd6;

    function automatic dir_state_t light_state(input logic [2:0] light);
        case (light)
            LIGHT_RED: return DIR_RED;
            LIGHT_YEL: return DIR_YELLOW;
            LIGHT_GRN: return DIR_GREEN;
            default:   return DIR_ILLEGAL;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/tl_dir_tracker.sv
// ============================================================================
// Module   : tl_dir_tracker
// Brief    : Per-direction previous-sample register, saturating run counter
//            and sequencing / phase-duration checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl_dir_tracker #(
    parameter int GREEN_MIN     = 4,
    parameter int YELLOW_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_sample,
    output logic       o_seq_err,
    output logic       o_green_short,
    output logic       o_yellow_len,
    output logic       o_green_to_yel
);
    import traffic_pkg::*;

    localparam logic [CNT_W-1:0] c_run_max = '1;

    logic [2:0]       r_prev;
    logic [CNT_W-1:0] r_run;
    dir_state_t       w_cur;
    dir_state_t       w_prv;

    assign w_cur = light_state(i_sample);
    assign w_prv = light_state(r_prev);

    // ILLEGAL on either side falls through every comparison below
    assign o_seq_err = ((w_prv == DIR_RED)    && (w_cur == DIR_YELLOW)) ||
                       ((w_prv == DIR_GREEN)  && (w_cur == DIR_RED))    ||
                       ((w_prv == DIR_YELLOW) && (w_cur == DIR_GREEN));

    assign o_green_to_yel = (w_prv == DIR_GREEN) && (w_cur == DIR_YELLOW);
    assign o_green_short  = o_green_to_yel && (r_run < CNT_W'(GREEN_MIN));
    assign o_yellow_len   = (w_prv == DIR_YELLOW) && (w_cur == DIR_RED) &&
                            (r_run != CNT_W'(YELLOW_CYCLES));

    // r_run is the length of the run that ends in r_prev
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= LIGHT_RED;
            r_run  <= '0;
        end else begin
            r_prev <= i_sample;
            if (i_sample != r_prev) begin
                r_run <= CNT_W'(1);
            end else if (r_run != c_run_max) begin
                r_run <= r_run + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/traffic_light_monitor.sv
// ============================================================================
// Module   : traffic_light_monitor
// Brief    : Passive checker for NS/EW light buses: encoding, conflict,
//            sequencing and duration errors. Optional stall watchdog is
//            enabled with macro TRAFFIC_MON_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_light_monitor #(
    parameter int GREEN_MIN     = 4,
    parameter int YELLOW_CYCLES = 2,
    parameter int CNT_W         = 8,
    parameter int WDOG_CYCLES   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  NS_light,
    input  logic [2:0]  EW_light,
    output logic        err_valid,
    output logic [2:0]  err_code,
    output logic [2:0]  first_err,
    output logic [7:0]  err_count,
    output logic [15:0] cycle_count
);
    import traffic_pkg::*;

    logic [2:0] r_ns_q;
    logic [2:0] r_ew_q;
    logic       w_ns_seq, w_ns_gs, w_ns_yl, w_ns_gy;
    logic       w_ew_seq, w_ew_gs, w_ew_yl, w_ew_gy;
    logic       w_ns_legal, w_ew_legal;
    logic       w_enc, w_conflict, w_wdog;
    logic [2:0] w_code;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ns_q <= LIGHT_RED;
            r_ew_q <= LIGHT_RED;
        end else begin
            r_ns_q <= NS_light;
            r_ew_q <= EW_light;
        end
    end

    tl_dir_tracker #(
        .GREEN_MIN     (GREEN_MIN),
        .YELLOW_CYCLES (YELLOW_CYCLES),
        .CNT_W         (CNT_W)
    ) u_ns (
        .clk            (clk),
        .rst            (rst),
        .i_sample       (r_ns_q),
        .o_seq_err      (w_ns_seq),
        .o_green_short  (w_ns_gs),
        .o_yellow_len   (w_ns_yl),
        .o_green_to_yel (w_ns_gy)
    );

    tl_dir_tracker #(
        .GREEN_MIN     (GREEN_MIN),
        .YELLOW_CYCLES (YELLOW_CYCLES),
        .CNT_W         (CNT_W)
    ) u_ew (
        .clk            (clk),
        .rst            (rst),
        .i_sample       (r_ew_q),
        .o_seq_err      (w_ew_seq),
        .o_green_short  (w_ew_gs),
        .o_yellow_len   (w_ew_yl),
        .o_green_to_yel (w_ew_gy)
    );

    assign w_ns_legal = (light_state(r_ns_q) != DIR_ILLEGAL);
    assign w_ew_legal = (light_state(r_ew_q) != DIR_ILLEGAL);
    assign w_enc      = !w_ns_legal || !w_ew_legal;
    assign w_conflict = w_ns_legal && w_ew_legal &&
                        (r_ns_q != LIGHT_RED) && (r_ew_q != LIGHT_RED);

`ifdef TRAFFIC_MON_WATCHDOG_EN
    localparam int c_stall_w = $clog2(WDOG_CYCLES + 1);

    logic [c_stall_w-1:0] r_stall;
    logic [5:0]           r_last;
    logic                 w_same;

    assign w_same = ({r_ns_q, r_ew_q} == r_last);
    // Fires on the step that brings the counter to the limit, then holds
    assign w_wdog = w_same && (r_stall == c_stall_w'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall <= '0;
            r_last  <= {LIGHT_RED, LIGHT_RED};
        end else begin
            r_last <= {r_ns_q, r_ew_q};
            if (!w_same) begin
                r_stall <= '0;
            end else if (r_stall != c_stall_w'(WDOG_CYCLES)) begin
                r_stall <= r_stall + c_stall_w'(1);
            end
        end
    end
`else
    assign w_wdog = 1'b0;
`endif

    always_comb begin
        w_code = ERR_NONE;
        if (w_enc) begin
            w_code = ERR_ENC;
        end else if (w_conflict) begin
            w_code = ERR_CONFLICT;
        end else if (w_ns_seq || w_ew_seq) begin
            w_code = ERR_SEQ;
        end else if (w_ns_gs || w_ew_gs) begin
            w_code = ERR_GREEN_SHORT;
        end else if (w_ns_yl || w_ew_yl) begin
            w_code = ERR_YELLOW_LEN;
        end else if (w_wdog) begin
            w_code = ERR_WDOG;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_valid   <= 1'b0;
            err_code    <= ERR_NONE;
            first_err   <= ERR_NONE;
            err_count   <= 8'd0;
            cycle_count <= 16'd0;
        end else begin
            err_valid <= (w_code != ERR_NONE);
            err_code  <= w_code;
            if (first_err == ERR_NONE) begin
                first_err <= w_code;
            end
            if ((w_code != ERR_NONE) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            // EW green-to-yellow is checked for duration but never counted
            if (w_ns_gy || (w_ew_gy && 1'b0)) begin
                cycle_count <= cycle_count + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

- Passive protocol checker that sits on the NS_light/EW_light outputs of the basic traffic-light controller.
- Samples both light buses every clock and checks encoding, safety (no conflicting greens/yellows) and legal G→Y→R sequencing with phase durations.
- Reports errors through a one-cycle pulse, a sticky first-error code and a saturating error counter.
- Used in board bring-up and in simulation benches.

## Interface
Parameters:
- GREEN_MIN, 4: minimum green run length in cycles
- YELLOW_CYCLES, 2: exact required yellow run length in cycles
- CNT_W, 8: width of run-length counters, which saturate
- WDOG_CYCLES, 64: stall limit in cycles; used only with the watchdog macro

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- NS_light  in  3  north-south light: bit2 red, bit1 yellow, bit0 green
- EW_light  in  3  east-west light, same encoding
- err_valid  out  1  one-cycle pulse: an error was detected on the previous sample
- err_code  out  3  code of the pulsed error; 0 when err_valid=0
- first_err  out  3  code of the first error since reset; sticky
- err_count  out  8  number of cycles with any error; saturates at 255
- cycle_count  out  16  number of completed NS green→yellow transitions; wraps

## Operation
Sampling:
- Inputs are registered each edge into ns_q/ew_q.
- All checks compare ns_q/ew_q against ns_prev/ew_prev, which hold the previous sample.
- Reset loads ns_prev = ew_prev = 3'b100 (red), so a first green after reset is legal.

Per-direction state: RED, GREEN, YELLOW, ILLEGAL. State is taken from the sample. A run counter counts consecutive identical samples; it counts the first sample as 1 and saturates at 2^CNT_W-1.

Error codes, checked every cycle:
- 1 ENC: either sample is not exactly one-hot.
- 2 CONFLICT: both samples legal and both non-red.
- 3 SEQ: illegal transition R→Y, G→R or Y→G on either direction.
- 4 GREEN_SHORT: G→Y transition with green run < GREEN_MIN.
- 5 YELLOW_LEN: Y→R transition with yellow run ≠ YELLOW_CYCLES.
- 6 WDOG: watchdog, only with the macro.

Rules:
- Several errors in the same cycle: the lowest code is reported. err_count increments by exactly 1.
- first_err is written only while it is 0.
- An ENC sample is not used for SEQ or duration checks. After an ENC sample the prev register still updates; ILLEGAL→anything is not a SEQ error.
- cycle_count increments on every legal NS G→Y transition, whether or not a GREEN_SHORT error also fires.

## Timing
- Latency: an illegal input present at edge k gives err_valid=1 and err_code during the cycle after edge k+1. Valid is high for exactly one cycle per erroneous sample.
- Reset values: err_valid=0, err_code=0, first_err=0, err_count=0, cycle_count=0, run counters=0.
- Reset asserted mid-operation clears everything immediately (asynchronous). Checking resumes with the prev registers at red.
- err_count holds at 255. cycle_count wraps from 65535 to 0.

## Configuration
Macro: TRAFFIC_MON_WATCHDOG_EN.
- When defined: a stall counter clears on any change of {NS,EW}. When it reaches WDOG_CYCLES it raises code 6 once, re-arming only after the next change.
- When not defined: no stall counter exists and code 6 never occurs.

## Structure
- Shared package traffic_pkg holds:
  - light encodings LIGHT_RED=3'b100, LIGHT_YEL=3'b010, LIGHT_GRN=3'b001
  - the direction-state enum
  - error code constants ERR_NONE..ERR_WDOG
- Sub-module tl_dir_tracker is instantiated twice, once for NS and once for EW. It holds the prev register, the run counter and the SEQ/GREEN_SHORT/YELLOW_LEN flags.
- The top level does the ENC/CONFLICT checks, priority encoding, counters and the watchdog.

## Test plan
- Legal cycle: NS G×5, Y×2, R with EW R; then EW G×5, Y×2, R → no err_valid, cycle_count=1.
- Conflict: NS=001 and EW=001 for one cycle → err_valid pulse, err_code=2, first_err=2, err_count=1.
- Sequence plus priority: NS G×5 then R → code 3. Then NS=011 → code 1 pulse; first_err stays 3; err_count=2.
- Durations: NS G×2 then Y → code 4. NS Y×3 then R → code 5. cycle_count increments on the G→Y.
- Saturation and reset: hold NS=111 for 300 cycles → err_count=255. Pulse rst low mid-run → all outputs 0 on the same edge.
- With TRAFFIC_MON_WATCHDOG_EN: hold NS=R, EW=R for 64 cycles → exactly one code-6 pulse. Without the macro → no pulse.
